// File: rtl/dmem_access_unit.sv
// Data-memory access unit: turns MEM-stage load/store requests into word-aligned
// bus transactions with lane steering, load extension, misalignment and watchdog errors.
module dmem_access_unit #(
  parameter int unsigned TIMEOUT_CYC = 0
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_we,
  input  logic [2:0]  req_ext,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        stall,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYC - 1);

  state_t      state;
  logic [31:0] addr_q;
  logic [3:0]  wstrb_q;
  logic [31:0] wdata_q;
  logic [2:0]  ext_q;
  logic        wr_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] wd_cnt;

  logic        is_load, is_byte, is_half, is_word, misaligned;
  logic [3:0]  mask_n;
  logic [31:0] wdata_n;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic        timeout;

  // Classify the incoming access by size; unknown store masks count as word stores
  // and unknown load extensions as full-word loads.
  always_comb begin
    is_load    = (req_we == 4'b0000);
    is_byte    = (req_we == 4'b0001) || (is_load && (req_ext == 3'd1 || req_ext == 3'd2));
    is_half    = (req_we == 4'b0011) || (is_load && (req_ext == 3'd3 || req_ext == 3'd4));
    is_word    = !is_byte && !is_half;
    misaligned = (is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00));
    mask_n     = '0;
    wdata_n    = req_wdata;
    if (!is_load) begin
      if (is_byte) begin
        mask_n  = 4'b0001;
        wdata_n = {4{req_wdata[7:0]}};
      end else if (is_half) begin
        mask_n  = 4'b0011;
        wdata_n = {2{req_wdata[15:0]}};
      end else begin
        mask_n  = 4'b1111;
      end
    end
  end

  always_comb begin
    case (addr_q[1:0])
      2'd0:    byte_sel = bus_rdata[7:0];
      2'd1:    byte_sel = bus_rdata[15:8];
      2'd2:    byte_sel = bus_rdata[23:16];
      default: byte_sel = bus_rdata[31:24];
    endcase
    half_sel = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (ext_q)
      3'd1:    load_data = {{24{byte_sel[7]}}, byte_sel};
      3'd2:    load_data = {24'd0, byte_sel};
      3'd3:    load_data = {{16{half_sel[15]}}, half_sel};
      3'd4:    load_data = {16'd0, half_sel};
      default: load_data = bus_rdata;
    endcase
    if (wr_q) load_data = '0;
  end

  // wd_cnt holds the number of dwell cycles already completed, so the limit is hit
  // on the edge that ends dwell cycle TIMEOUT_CYC.
  assign timeout = (TIMEOUT_CYC != 0) && (wd_cnt == WD_LAST);

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
      ext_q   <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      wd_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            wstrb_q <= mask_n << req_addr[1:0];
            wdata_q <= wdata_n;
            ext_q   <= req_ext;
            wr_q    <= !is_load;
            rdata_q <= '0;
            wd_cnt  <= '0;
            err_q   <= misaligned;
            state   <= misaligned ? S_RESP : S_REQ;
          end
        end
        S_REQ: begin
          wd_cnt <= wd_cnt + 32'd1;
          if (bus_addr_ok && bus_data_ok) begin
            rdata_q <= load_data;
            state   <= S_RESP;
          end else if (timeout) begin
            err_q <= 1'b1;
            state <= S_RESP;
          end else if (bus_addr_ok) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          wd_cnt <= wd_cnt + 32'd1;
          if (bus_data_ok) begin
            rdata_q <= load_data;
            state   <= S_RESP;
          end else if (timeout) begin
            err_q <= 1'b1;
            state <= S_RESP;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (state == S_IDLE);
  assign stall     = (state == S_REQ) || (state == S_WAIT) || ((state == S_IDLE) && req_valid);
  assign bus_req   = (state == S_REQ);
  assign bus_wr    = bus_req && wr_q;
  assign bus_addr  = {addr_q[31:2], 2'b00};
  assign bus_wstrb = bus_req ? wstrb_q : '0;
  assign bus_wdata = wdata_q;
  assign rsp_valid = (state == S_RESP);
  assign rsp_rdata = rsp_valid ? rdata_q : '0;
  assign rsp_err   = rsp_valid && err_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed self-checking bench for dmem_access_unit with an 8-cycle bus watchdog.
module tb_dmem_access_unit;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [3:0]  req_we;
  logic [2:0]  req_ext;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        stall;
  logic        bus_req;
  logic        bus_wr;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  int n_cmp = 0;
  int n_err = 0;

  dmem_access_unit #(.TIMEOUT_CYC(8)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_ext(req_ext), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .stall(stall),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_addr(bus_addr),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [3:0] we, input logic [2:0] ext,
                       input logic [31:0] wd);
    req_addr  = a;
    req_we    = we;
    req_ext   = ext;
    req_wdata = wd;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    cpu_rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_we = '0; req_ext = '0;
    req_wdata = '0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
    tick(); tick();
    chk("rst_ready", req_ready, 1);
    chk("rst_stall", stall, 0);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_wstrb", bus_wstrb, 0);
    chk("rst_bus_wr", bus_wr, 0);
    cpu_rst = 1'b0;
    tick();

    // data_ok while idle must not produce a response
    bus_data_ok = 1'b1; bus_rdata = 32'h5555_5555;
    tick();
    bus_data_ok = 1'b0;
    chk("idle_dataok_ignored", rsp_valid, 0);

    // ld.b 0x1003, data_ok one cycle after addr_ok
    req_addr = 32'h0000_1003; req_we = 4'b0000; req_ext = 3'd1; req_valid = 1'b1;
    #1;
    chk("idle_valid_stall", stall, 1);
    tick();
    req_valid = 1'b0;
    chk("ldb_bus_req", bus_req, 1);
    chk("ldb_bus_addr", bus_addr, 32'h0000_1000);
    chk("ldb_bus_wr", bus_wr, 0);
    chk("ldb_wstrb", bus_wstrb, 0);
    chk("ldb_ready", req_ready, 0);
    bus_addr_ok = 1'b1;
    tick();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h80FF_0000;
    chk("ldb_wait_bus_req", bus_req, 0);
    chk("ldb_wait_no_rsp", rsp_valid, 0);
    chk("ldb_wait_stall", stall, 1);
    tick();
    bus_data_ok = 1'b0;
    chk("ldb_rsp_valid", rsp_valid, 1);
    chk("ldb_rdata", rsp_rdata, 32'hFFFF_FF80);
    chk("ldb_err", rsp_err, 0);
    chk("ldb_resp_stall", stall, 0);
    chk("ldb_resp_ready", req_ready, 0);
    tick();
    chk("ldb_pulse_end", rsp_valid, 0);
    chk("ldb_back_idle", req_ready, 1);

    // st.h 0x2002, addr_ok and data_ok together
    issue(32'h0000_2002, 4'b0011, 3'd0, 32'h1234_ABCD);
    chk("sth_bus_wr", bus_wr, 1);
    chk("sth_wstrb", bus_wstrb, 4'b1100);
    chk("sth_wdata", bus_wdata, 32'hABCD_ABCD);
    chk("sth_bus_addr", bus_addr, 32'h0000_2000);
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    tick();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    chk("sth_rsp_valid", rsp_valid, 1);
    chk("sth_err", rsp_err, 0);
    chk("sth_rdata", rsp_rdata, 0);
    tick();

    // ld.hu 0x3001: misaligned
    issue(32'h0000_3001, 4'b0000, 3'd4, 32'h0);
    chk("ldhu_no_bus_req", bus_req, 0);
    chk("ldhu_rsp_valid", rsp_valid, 1);
    chk("ldhu_err", rsp_err, 1);
    chk("ldhu_rdata", rsp_rdata, 0);
    tick();
    chk("ldhu_pulse_end", rsp_valid, 0);

    // st.b 0x4001
    issue(32'h0000_4001, 4'b0001, 3'd0, 32'h0000_00A5);
    chk("stb_wstrb", bus_wstrb, 4'b0010);
    chk("stb_wdata", bus_wdata, 32'hA5A5_A5A5);
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1;
    tick();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    chk("stb_rsp_valid", rsp_valid, 1);
    tick();

    // lh 0x5002: upper half, sign extended
    issue(32'h0000_5002, 4'b0000, 3'd3, 32'h0);
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h8001_7FFF;
    tick();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    chk("lh_rdata", rsp_rdata, 32'hFFFF_8001);
    tick();

    // lbu 0x5001: byte lane 1, zero extended
    issue(32'h0000_5001, 4'b0000, 3'd2, 32'h0);
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h1234_F0AB;
    tick();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    chk("lbu_rdata", rsp_rdata, 32'h0000_00F0);
    tick();

    // ext 6 behaves as a full-word load
    issue(32'h0000_5004, 4'b0000, 3'd6, 32'h0);
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h8765_4321;
    tick();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    chk("ext6_rdata", rsp_rdata, 32'h8765_4321);
    tick();

    // lw 0x6002: misaligned word
    issue(32'h0000_6002, 4'b0000, 3'd0, 32'h0);
    chk("lw_mis_bus_req", bus_req, 0);
    chk("lw_mis_err", rsp_err, 1);
    tick();

    // odd store mask 0101 treated as a word store
    issue(32'h0000_7000, 4'b0101, 3'd0, 32'hCAFE_F00D);
    chk("oddwe_wstrb", bus_wstrb, 4'b1111);
    chk("oddwe_wdata", bus_wdata, 32'hCAFE_F00D);
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1;
    tick();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    chk("oddwe_rsp", rsp_valid, 1);
    tick();

    // sw 0x8004 with addr_ok held low 5 cycles; early data_ok is ignored
    issue(32'h0000_8004, 4'b1111, 3'd0, 32'h1122_3344);
    bus_data_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("hold_bus_req", bus_req, 1);
      chk("hold_bus_addr", bus_addr, 32'h0000_8004);
      chk("hold_wstrb", bus_wstrb, 4'b1111);
      chk("hold_stall", stall, 1);
      chk("hold_no_rsp", rsp_valid, 0);
      tick();
    end
    bus_data_ok = 1'b0; bus_addr_ok = 1'b1;
    chk("hold_last_bus_req", bus_req, 1);
    tick();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1;
    chk("hold_wait_no_rsp", rsp_valid, 0);
    tick();
    bus_data_ok = 1'b0;
    chk("hold_rsp_valid", rsp_valid, 1);
    chk("hold_rsp_err", rsp_err, 0);
    tick();
    chk("hold_single_rsp", rsp_valid, 0);

    // watchdog: addr_ok given, data_ok never arrives
    issue(32'h0000_9000, 4'b0000, 3'd0, 32'h0);
    bus_addr_ok = 1'b1;
    tick();
    bus_addr_ok = 1'b0;
    for (int i = 2; i <= 8; i++) begin
      chk("wd_no_rsp_yet", rsp_valid, 0);
      chk("wd_stall", stall, 1);
      tick();
    end
    chk("wd_rsp_valid", rsp_valid, 1);
    chk("wd_rsp_err", rsp_err, 1);
    chk("wd_rdata", rsp_rdata, 0);
    tick();
    chk("wd_back_idle", req_ready, 1);

    // reset during WAIT, data_ok arriving afterwards
    issue(32'h0000_A000, 4'b0000, 3'd0, 32'h0);
    bus_addr_ok = 1'b1;
    tick();
    bus_addr_ok = 1'b0; cpu_rst = 1'b1;
    tick();
    cpu_rst = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h1357_9BDF;
    chk("rstw_ready", req_ready, 1);
    chk("rstw_bus_req", bus_req, 0);
    chk("rstw_no_rsp", rsp_valid, 0);
    tick();
    bus_data_ok = 1'b0;
    chk("rstw_late_dataok", rsp_valid, 0);
    chk("rstw_ready2", req_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
